// File: rtl/mmio_bus_arbiter.sv
// Two-port (core / debugger) arbiter onto a single-outstanding MMIO bus.
// Ties alternate via last_grant; a stalled bus is aborted after TIMEOUT wait cycles.
module mmio_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // core MEM-stage port
    input  logic        i_c_req,
    input  logic        i_c_we,
    input  logic [1:0]  i_c_size,
    input  logic [63:0] i_c_addr,
    input  logic [63:0] i_c_wdata,
    input  logic        i_c_flush,
    output logic        o_c_done,
    output logic        o_c_err,
    output logic [63:0] o_c_rdata,
    output logic        o_c_stall_c,
    // debugger port
    input  logic        i_g_req,
    input  logic        i_g_we,
    input  logic [1:0]  i_g_size,
    input  logic [63:0] i_g_addr,
    input  logic [63:0] i_g_wdata,
    output logic        o_g_done,
    output logic        o_g_err,
    output logic [63:0] o_g_rdata,
    // downstream MMIO bus
    output logic        o_m_valid,
    output logic        o_m_we,
    output logic [1:0]  o_m_size,
    output logic [63:0] o_m_addr,
    output logic [63:0] o_m_wdata,
    input  logic        i_m_ready,
    input  logic [63:0] i_m_rdata,
    output logic [1:0]  o_busy_owner
);

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 16;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]       OWN_NONE  = 2'd0;
    localparam logic [1:0]       OWN_C     = 2'd1;
    localparam logic [1:0]       OWN_G     = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS_C = 2'd1,
        S_BUS_G = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mmio_req_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_last_grant_g;
    logic [CNT_W-1:0]  r_wait_cnt;
    mmio_req_t         r_m_req;
    logic              r_m_valid;
    logic              r_c_done;
    logic              r_c_err;
    logic [DATA_W-1:0] r_c_rdata;
    logic              r_g_done;
    logic              r_g_err;
    logic [DATA_W-1:0] r_g_rdata;
    logic [1:0]        r_busy_owner;

    logic              w_c_valid;
    logic              w_g_valid;
    logic              w_grant_c;
    logic              w_grant_g;
    logic              w_bus_ok;
    logic              w_bus_to;
    logic              w_owner_g;
    mmio_req_t         w_c_req;
    mmio_req_t         w_g_req;

    // A flushed or size-0 request is invisible to arbitration.
    assign w_c_valid = i_c_req & ~i_c_flush & (i_c_size != 2'd0);
    assign w_g_valid = i_g_req & (i_g_size != 2'd0);
    assign w_owner_g = (r_state == S_BUS_G);

    assign w_c_req = '{we: i_c_we, size: i_c_size, addr: i_c_addr, wdata: i_c_wdata};
    assign w_g_req = '{we: i_g_we, size: i_g_size, addr: i_g_addr, wdata: i_g_wdata};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, grant and bus-completion decode
    always_comb begin
        w_next_state = r_state;
        w_grant_c    = 1'b0;
        w_grant_g    = 1'b0;
        w_bus_ok     = 1'b0;
        w_bus_to     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_c_valid && w_g_valid) begin
                    w_grant_c = r_last_grant_g;
                    w_grant_g = ~r_last_grant_g;
                end else begin
                    w_grant_c = w_c_valid;
                    w_grant_g = w_g_valid;
                end
                if (w_grant_c) begin
                    w_next_state = S_BUS_C;
                end else if (w_grant_g) begin
                    w_next_state = S_BUS_G;
                end
            end
            S_BUS_C, S_BUS_G: begin
                // ready in the timeout cycle still counts as a normal completion
                if (i_m_ready) begin
                    w_bus_ok = 1'b1;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_bus_to = 1'b1;
                end
                if (w_bus_ok || w_bus_to) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Bus request, wait counter and per-port completion registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant_g <= 1'b1;
            r_wait_cnt     <= '0;
            r_m_req        <= '0;
            r_m_valid      <= 1'b0;
            r_c_done       <= 1'b0;
            r_c_err        <= 1'b0;
            r_c_rdata      <= '0;
            r_g_done       <= 1'b0;
            r_g_err        <= 1'b0;
            r_g_rdata      <= '0;
            r_busy_owner   <= OWN_NONE;
        end else begin
            r_c_done <= 1'b0;
            r_c_err  <= 1'b0;
            r_g_done <= 1'b0;
            r_g_err  <= 1'b0;

            if (w_grant_c || w_grant_g) begin
                r_m_req        <= w_grant_g ? w_g_req : w_c_req;
                r_m_valid      <= 1'b1;
                r_wait_cnt     <= '0;
                r_last_grant_g <= w_grant_g;
                r_busy_owner   <= w_grant_g ? OWN_G : OWN_C;
            end

            if (w_bus_ok || w_bus_to) begin
                r_m_valid <= 1'b0;
                if (w_owner_g) begin
                    r_g_rdata <= w_bus_ok ? i_m_rdata : '0;
                    r_g_done  <= 1'b1;
                    r_g_err   <= w_bus_to;
                end else begin
                    r_c_rdata <= w_bus_ok ? i_m_rdata : '0;
                    r_c_done  <= 1'b1;
                    r_c_err   <= w_bus_to;
                end
            end else if (r_state == S_BUS_C || r_state == S_BUS_G) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end

            if (r_state == S_DONE) begin
                r_busy_owner <= OWN_NONE;
            end
        end
    end

    assign o_c_stall_c  = i_c_req & ~r_c_done & ~i_c_flush;
    assign o_c_done     = r_c_done;
    assign o_c_err      = r_c_err;
    assign o_c_rdata    = r_c_rdata;
    assign o_g_done     = r_g_done;
    assign o_g_err      = r_g_err;
    assign o_g_rdata    = r_g_rdata;
    assign o_m_valid    = r_m_valid;
    assign o_m_we       = r_m_req.we;
    assign o_m_size     = r_m_req.size;
    assign o_m_addr     = r_m_req.addr;
    assign o_m_wdata    = r_m_req.wdata;
    assign o_busy_owner = r_busy_owner;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Scoreboard bench for mmio_bus_arbiter: stimulus queues expected bus requests and
// completions; a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_mmio_bus_arbiter;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, c_flush;
    logic [1:0]  c_size;
    logic [63:0] c_addr, c_wdata;
    logic        c_done, c_err, c_stall;
    logic [63:0] c_rdata;
    logic        g_req, g_we;
    logic [1:0]  g_size;
    logic [63:0] g_addr, g_wdata;
    logic        g_done, g_err;
    logic [63:0] g_rdata;
    logic        m_valid, m_we, m_ready;
    logic [1:0]  m_size;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  busy_owner;

    always #5 clk = ~clk;

    mmio_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_c_req(c_req), .i_c_we(c_we), .i_c_size(c_size), .i_c_addr(c_addr),
        .i_c_wdata(c_wdata), .i_c_flush(c_flush),
        .o_c_done(c_done), .o_c_err(c_err), .o_c_rdata(c_rdata), .o_c_stall_c(c_stall),
        .i_g_req(g_req), .i_g_we(g_we), .i_g_size(g_size), .i_g_addr(g_addr),
        .i_g_wdata(g_wdata),
        .o_g_done(g_done), .o_g_err(g_err), .o_g_rdata(g_rdata),
        .o_m_valid(m_valid), .o_m_we(m_we), .o_m_size(m_size), .o_m_addr(m_addr),
        .o_m_wdata(m_wdata), .i_m_ready(m_ready), .i_m_rdata(m_rdata),
        .o_busy_owner(busy_owner)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  owner;
    } bus_exp_t;

    typedef struct {
        logic [1:0]  port;
        logic        err;
        logic [63:0] rdata;
        int          vcyc;
    } rsp_exp_t;

    bus_exp_t bq[$];
    rsp_exp_t rq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_grant  = 0;
    int n_done   = 0;

    int          rsp_delay = 0;
    logic [63:0] rsp_data  = '0;
    logic        rsp_force = 1'b0;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not permitted here", name);
    endtask

    task automatic push_bus(input logic we, input logic [1:0] size, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [1:0] owner);
        bus_exp_t e;
        e.we = we; e.size = size; e.addr = addr; e.wdata = wdata; e.owner = owner;
        bq.push_back(e);
    endtask

    task automatic push_rsp(input logic [1:0] port, input logic err, input logic [63:0] rdata,
                            input int vcyc);
        rsp_exp_t e;
        e.port = port; e.err = err; e.rdata = rdata; e.vcyc = vcyc;
        rq.push_back(e);
    endtask

    task automatic core_txn(input logic we, input logic [1:0] size, input logic [63:0] addr,
                            input logic [63:0] wdata);
        int k;
        c_we = we; c_size = size; c_addr = addr; c_wdata = wdata; c_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!c_done && k < 60);
        if (!c_done) fail_msg("core_done_wait");
        c_req = 1'b0;
    endtask

    task automatic dbg_txn(input logic we, input logic [1:0] size, input logic [63:0] addr,
                           input logic [63:0] wdata);
        int k;
        g_we = we; g_size = size; g_addr = addr; g_wdata = wdata; g_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!g_done && k < 60);
        if (!g_done) fail_msg("dbg_done_wait");
        g_req = 1'b0;
    endtask

    // Bus responder: asserts m_ready for one cycle rsp_delay cycles after m_valid
    initial begin
        int cnt;
        m_ready = 1'b0;
        m_rdata = '0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ready = 1'b0;
                cnt = 0;
            end else if (rsp_force) begin
                m_ready = 1'b1;
            end else if (m_ready) begin
                m_ready = 1'b0;
                cnt = 0;
            end else if (m_valid && rsp_delay >= 0) begin
                if (cnt == rsp_delay) begin
                    m_ready = 1'b1;
                    m_rdata = rsp_data;
                end else begin
                    cnt++;
                end
            end else if (!m_valid) begin
                cnt = 0;
            end
        end
    end

    // Monitor: grants against bq, completions against rq
    initial begin
        logic     prev_v;
        int       vcnt;
        bus_exp_t be;
        rsp_exp_t re;
        prev_v = 1'b0;
        vcnt = 0;
        be = '{default: '0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
                vcnt = 0;
            end else begin
                if (m_valid && !prev_v) begin
                    n_grant++;
                    vcnt = 1;
                    if (bq.size() == 0) begin
                        fail_msg("unexpected_grant");
                    end else begin
                        be = bq.pop_front();
                        chk1("grant_we", m_we, be.we);
                        chk64("grant_size", 64'(m_size), 64'(be.size));
                        chk64("grant_addr", m_addr, be.addr);
                        chk64("grant_wdata", m_wdata, be.wdata);
                        chk64("grant_owner", 64'(busy_owner), 64'(be.owner));
                    end
                end else if (m_valid) begin
                    vcnt++;
                    chk64("hold_addr", m_addr, be.addr);
                end
                if (c_done || g_done) begin
                    n_done++;
                    if (c_done && g_done) fail_msg("double_done");
                    if (rq.size() == 0) begin
                        fail_msg("unexpected_done");
                    end else begin
                        re = rq.pop_front();
                        chk64("done_port", 64'({g_done, c_done}), 64'(re.port));
                        chk1("done_err", c_done ? c_err : g_err, re.err);
                        chk64("done_rdata", c_done ? c_rdata : g_rdata, re.rdata);
                        chki("valid_cycles", vcnt, re.vcyc);
                        chk1("done_latency", prev_v, 1'b1);
                    end
                    vcnt = 0;
                end
                prev_v = m_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, d0;
        rst_n = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_size = 2'd0; c_addr = '0; c_wdata = '0; c_flush = 1'b0;
        g_req = 1'b0; g_we = 1'b0; g_size = 2'd0; g_addr = '0; g_wdata = '0;
        repeat (3) @(negedge clk);

        chk1("rst_m_valid", m_valid, 1'b0);
        chk1("rst_m_we", m_we, 1'b0);
        chk64("rst_m_size", 64'(m_size), 64'd0);
        chk64("rst_m_addr", m_addr, 64'd0);
        chk64("rst_m_wdata", m_wdata, 64'd0);
        chk1("rst_c_done", c_done, 1'b0);
        chk1("rst_c_err", c_err, 1'b0);
        chk1("rst_g_done", g_done, 1'b0);
        chk1("rst_g_err", g_err, 1'b0);
        chk64("rst_c_rdata", c_rdata, 64'd0);
        chk64("rst_g_rdata", g_rdata, 64'd0);
        chk64("rst_busy", 64'(busy_owner), 64'd0);
        chk1("rst_stall", c_stall, 1'b0);

        // core load, ready 2 cycles after m_valid; grant in first cycle after release
        rsp_delay = 2; rsp_data = 64'h1122_3344_5566_7788;
        push_bus(1'b0, 2'd3, 64'h2000_0008, 64'd0, 2'd1);
        push_rsp(2'd1, 1'b0, 64'h1122_3344_5566_7788, 3);
        rst_n = 1'b1;
        fork
            core_txn(1'b0, 2'd3, 64'h2000_0008, 64'd0);
            begin
                @(negedge clk);
                chk1("first_grant", m_valid, 1'b1);
                chk1("stall_waiting", c_stall, 1'b1);
            end
        join

        // core byte store, immediate ready; store also captures bus data
        rsp_delay = 0; rsp_data = 64'h5A;
        push_bus(1'b1, 2'd1, 64'h3000_0001, 64'hA5, 2'd1);
        push_rsp(2'd1, 1'b0, 64'h5A, 1);
        core_txn(1'b1, 2'd1, 64'h3000_0001, 64'hA5);

        // debugger word load; core rdata must hold
        rsp_delay = 1; rsp_data = 64'hDEAD_BEEF_CAFE_F00D;
        push_bus(1'b0, 2'd2, 64'h4000_0010, 64'd0, 2'd2);
        push_rsp(2'd2, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 2);
        dbg_txn(1'b0, 2'd2, 64'h4000_0010, 64'd0);
        chk64("c_rdata_hold", c_rdata, 64'h5A);

        // tie with both held: core, debugger, core, debugger
        rsp_delay = 0; rsp_data = 64'h0123_4567_89AB_CDEF;
        push_bus(1'b0, 2'd3, 64'h100, 64'd0, 2'd1);
        push_bus(1'b0, 2'd3, 64'h200, 64'd0, 2'd2);
        push_bus(1'b0, 2'd3, 64'h108, 64'd0, 2'd1);
        push_bus(1'b0, 2'd3, 64'h208, 64'd0, 2'd2);
        push_rsp(2'd1, 1'b0, 64'h0123_4567_89AB_CDEF, 1);
        push_rsp(2'd2, 1'b0, 64'h0123_4567_89AB_CDEF, 1);
        push_rsp(2'd1, 1'b0, 64'h0123_4567_89AB_CDEF, 1);
        push_rsp(2'd2, 1'b0, 64'h0123_4567_89AB_CDEF, 1);
        fork
            begin
                core_txn(1'b0, 2'd3, 64'h100, 64'd0);
                core_txn(1'b0, 2'd3, 64'h108, 64'd0);
            end
            begin
                dbg_txn(1'b0, 2'd3, 64'h200, 64'd0);
                dbg_txn(1'b0, 2'd3, 64'h208, 64'd0);
            end
        join

        // debugger store with no ready: timeout after 4 valid cycles
        rsp_delay = -1;
        push_bus(1'b1, 2'd3, 64'h5000_0000, 64'h55AA_55AA_55AA_55AA, 2'd2);
        push_rsp(2'd2, 1'b1, 64'd0, 4);
        dbg_txn(1'b1, 2'd3, 64'h5000_0000, 64'h55AA_55AA_55AA_55AA);

        // ready exactly in the timeout cycle: normal completion wins
        rsp_delay = 3; rsp_data = 64'h0F0F_0F0F_0F0F_0F0F;
        push_bus(1'b0, 2'd3, 64'h6000_0000, 64'd0, 2'd1);
        push_rsp(2'd1, 1'b0, 64'h0F0F_0F0F_0F0F_0F0F, 4);
        core_txn(1'b0, 2'd3, 64'h6000_0000, 64'd0);

        // core request arrives while debugger owns the bus, flushed in the idle cycle
        rsp_delay = 3; rsp_data = 64'h77;
        push_bus(1'b0, 2'd2, 64'h4000_0100, 64'd0, 2'd2);
        push_rsp(2'd2, 1'b0, 64'h77, 4);
        g0 = n_grant; d0 = n_done;
        fork
            dbg_txn(1'b0, 2'd2, 64'h4000_0100, 64'd0);
            begin
                @(negedge clk);
                c_we = 1'b0; c_size = 2'd3; c_addr = 64'h7000_0000; c_req = 1'b1;
                @(negedge clk);
                chk1("stall_pending", c_stall, 1'b1);
            end
        join
        @(negedge clk);
        c_flush = 1'b1;
        #1 chk1("stall_flush", c_stall, 1'b0);
        @(negedge clk);
        c_req = 1'b0; c_flush = 1'b0;
        repeat (6) @(negedge clk);
        chki("flush_grants", n_grant - g0, 1);
        chki("flush_dones", n_done - d0, 1);

        // flush during a granted core transaction still completes
        rsp_delay = 2; rsp_data = 64'h99;
        push_bus(1'b0, 2'd3, 64'h7100_0000, 64'd0, 2'd1);
        push_rsp(2'd1, 1'b0, 64'h99, 3);
        fork
            core_txn(1'b0, 2'd3, 64'h7100_0000, 64'd0);
            begin
                @(negedge clk);
                c_flush = 1'b1;
                @(negedge clk);
                c_flush = 1'b0;
            end
        join

        // size-0 requests are never granted
        g0 = n_grant; d0 = n_done;
        c_size = 2'd0; c_addr = 64'h9000_0000; c_req = 1'b1;
        g_size = 2'd0; g_addr = 64'h9100_0000; g_req = 1'b1;
        repeat (8) @(negedge clk);
        c_req = 1'b0; g_req = 1'b0;
        chki("size0_grants", n_grant - g0, 0);
        chki("size0_dones", n_done - d0, 0);

        // m_ready while idle is ignored
        g0 = n_grant; d0 = n_done;
        rsp_force = 1'b1;
        repeat (4) @(negedge clk);
        chk1("idle_ready_valid", m_valid, 1'b0);
        chk64("idle_ready_busy", 64'(busy_owner), 64'd0);
        rsp_force = 1'b0;
        repeat (2) @(negedge clk);
        chki("idle_ready_dones", n_done - d0, 0);

        // reset in the middle of a core bus cycle
        rsp_delay = -1;
        push_bus(1'b0, 2'd3, 64'h8000_0000, 64'd0, 2'd1);
        d0 = n_done;
        c_we = 1'b0; c_size = 2'd3; c_addr = 64'h8000_0000; c_wdata = '0; c_req = 1'b1;
        @(negedge clk);
        chk1("pre_reset_valid", m_valid, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk1("async_rst_valid", m_valid, 1'b0);
        chk64("async_rst_busy", 64'(busy_owner), 64'd0);
        c_req = 1'b0;
        bq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        g0 = n_grant;
        repeat (8) @(negedge clk);
        chki("post_rst_dones", n_done - d0, 0);
        chki("post_rst_grants", n_grant - g0, 0);

        // tie after reset goes to the core
        rsp_delay = 0; rsp_data = 64'h42;
        push_bus(1'b0, 2'd3, 64'h8100_0000, 64'd0, 2'd1);
        push_bus(1'b0, 2'd3, 64'h8200_0000, 64'd0, 2'd2);
        push_rsp(2'd1, 1'b0, 64'h42, 1);
        push_rsp(2'd2, 1'b0, 64'h42, 1);
        fork
            core_txn(1'b0, 2'd3, 64'h8100_0000, 64'd0);
            dbg_txn(1'b0, 2'd3, 64'h8200_0000, 64'd0);
        join
        repeat (3) @(negedge clk);

        chki("bus_queue_empty", bq.size(), 0);
        chki("rsp_queue_empty", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_bus_arbiter.md
MMIO_BUS_ARBITER -- requirements
Module: mmio_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, bus-wait cycles before the arbiter aborts a transaction; legal range 1..65535.
REQ-002 clock  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; reset asserted (0) forces the reset state immediately, and release is sampled on clock.
REQ-004 c_req  in  1  core MEM-stage MMIO request; held high with payload stable until c_done.
REQ-005 c_we / c_size / c_addr / c_wdata  in  1/2/64/64  core write-enable, size (1=byte, 2=word, 3=dword, 0 illegal), address, store data.
REQ-006 c_flush  in  1  pipeline flush; cancels an ungranted core request.
REQ-007 c_done / c_err / c_rdata / c_stall  out  1/1/64/1  core completion pulse, timeout flag, load data, stall-to-pipeline.
REQ-008 g_req / g_we / g_size / g_addr / g_wdata  in  1/1/2/64/64  debugger-port request with the same rules as the core port.
REQ-009 g_done / g_err / g_rdata  out  1/1/64  debugger completion pulse, timeout flag, load data.
REQ-010 m_valid / m_we / m_size / m_addr / m_wdata  out  1/1/2/64/64  downstream MMIO bus request, registered.
REQ-011 m_ready / m_rdata  in  1/64  downstream acceptance and load data, valid in the m_ready cycle.
REQ-012 busy_owner  out  2  debug view of the owner: 0=none, 1=core, 2=debugger.

Function
REQ-013 States: IDLE, BUS_C, BUS_G, DONE; one transaction is outstanding at most.
REQ-014 IDLE with exactly one valid request: grant that port next cycle.
- A core request is valid when c_req=1, c_flush=0 and c_size!=0.
- A debugger request is valid when g_req=1 and g_size!=0.
REQ-015 IDLE with both ports requesting: grant the port not recorded in last_grant, then update last_grant; last_grant resets to debugger, so the core wins the first tie.
REQ-016 On grant:
- latch we, size, addr and wdata into the m_* registers;
- set m_valid=1 in the first BUS_x cycle.
REQ-017 m_valid and the m_* payload stay constant while in BUS_x until m_ready=1 is sampled.
REQ-018 m_ready=1 in BUS_x:
- deassert m_valid next cycle;
- capture m_rdata into the owner's rdata register; store operations also capture it;
- go to DONE.
REQ-019 DONE lasts exactly 1 cycle: owner's done=1 and err=0, then go to IDLE; a new grant is possible in the following cycle, giving a minimum of 3 cycles per transaction (grant, bus, done).
REQ-020 wait_cnt (16-bit) clears on grant and increments each BUS_x cycle with m_ready=0.
REQ-021 When wait_cnt==TIMEOUT-1 and m_ready=0:
- drop m_valid;
- load the owner's rdata with 0;
- go to DONE with the owner's err=1.
REQ-022 When m_ready=1 in the same cycle as the timeout, the m_ready completion wins and err=0.
REQ-023 c_flush affects only an ungranted core request; a granted core transaction always completes and pulses c_done.
REQ-024 c_stall = c_req & ~c_done & ~c_flush, combinational.
REQ-025 c_rdata and g_rdata hold their value until that port's next completion.
REQ-026 m_ready outside BUS_x is ignored; it does not change state.
REQ-027 A request with size=0 is never granted, and its done is never pulsed.

Reset
REQ-028 When reset=0:
- state goes to IDLE;
- last_grant goes to debugger;
- wait_cnt goes to 0;
- m_valid, m_we, c_done, c_err, g_done and g_err go to 0;
- m_size, m_addr, m_wdata, c_rdata and g_rdata go to 0;
- busy_owner goes to 0.
REQ-029 Reset during BUS_x or DONE abandons the transaction, and no done pulse is issued after release.
REQ-030 The first grant is possible 1 cycle after reset is released.

Verification
REQ-031 Core load: c_req=1, size=3, addr=0x2000_0008, m_ready high 2 cycles after m_valid, m_rdata=0x1122334455667788 -> c_done pulse 1 cycle after m_ready, c_rdata=0x1122334455667788, c_err=0.
REQ-032 Tie: c_req and g_req rise together, held -> grants in the order core, debugger, core, debugger; each m_addr matches its owner.
REQ-033 Timeout: TIMEOUT=4, g_req store, m_ready held 0 -> m_valid high 4 cycles, then g_done=1, g_err=1, g_rdata=0.
REQ-034 Flush: g_req owns the bus; c_req arrives, then c_flush=1 for 1 cycle -> the core is never granted after the debugger completes and c_done never pulses; a granted core plus flush still gives c_done.
REQ-035 Reset mid-BUS_C: reset=0 while m_valid=1 -> m_valid=0 immediately, c_done never asserts after release, and the next tie grants the core.
REQ-036 Boundary: m_ready=1 exactly at wait_cnt==TIMEOUT-1 -> err=0 and rdata=m_ready data; size=0 request -> never granted.
